imem_loader: RTL and testbench

- Byte-stream boot loader: the write side of the instruction memory that the core fetches from.
- Accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into word-addressed instruction memory. Address N holds instruction N, matching the core's PC+1 sequencing.
- Holds the core in reset (cpu_hold) until a complete, verified image is loaded.

---
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader writing little-endian words into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR} state_t;
    localparam state_t FIN = CHECK;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
    localparam state_t FIN = DONE;
`endif
    localparam logic [ADDR_W:0] WC_ONE = {{ADDR_W{1'b0}}, 1'b1};
    state_t      state, nxt;
    logic [7:0]  len_lo;
    logic [15:0] len, new_len;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
    logic        xfer, launch, bad_len, last, word_end;
    assign byte_ready = state != IDLE && state != DONE && state != ERR;
    assign xfer       = byte_valid & byte_ready;
    assign launch     = start & ~byte_ready;
    assign new_len    = {byte_data, len_lo};
    assign bad_len    = new_len == 16'd0 || 32'(new_len) > (32'd1 << ADDR_W);
    assign last       = 32'(word_count) + 32'd1 == 32'(len);
    assign word_end   = state == DATA && xfer && byte_cnt == 2'd3;
    always_ff @(posedge CLK)
        state <= !RST_N ? IDLE : nxt;
    always_comb begin
        nxt = state;
        case (state)
            LEN_LO:  if (xfer) nxt = LEN_HI;
            LEN_HI:  if (xfer) nxt = bad_len ? ERR : DATA;
            DATA:    if (word_end && last) nxt = FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:   if (xfer) nxt = byte_data == csum ? DONE : ERR;
`endif
            default: if (start) nxt = LEN_LO;
        endcase
    end
    // Status flags follow the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            len_lo     <= '0;
            len        <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            mem_we   <= 1'b0;
            busy     <= nxt != IDLE && nxt != DONE && nxt != ERR;
            done     <= nxt == DONE;
            error    <= nxt == ERR;
            cpu_hold <= nxt != DONE;
            if (launch) begin
                word_count <= '0;
                byte_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
            end
            if (state == LEN_LO && xfer)
                len_lo <= byte_data;
            if (state == LEN_HI && xfer)
                len <= new_len;
            if (state == DATA && xfer) begin
                asm_q    <= {byte_data, asm_q[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum ^ byte_data;
`endif
            end
            if (word_end) begin
                mem_we     <= 1'b1;
                mem_wdata  <= {byte_data, asm_q};
                mem_addr   <= word_count[ADDR_W-1:0];
                word_count <= word_count + WC_ONE;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame loads checked against a frame-level model of the loader.
module tb_imem_loader;
    logic        CLK = 1'b0, RST_N = 1'b0, start = 1'b0, byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, cpu_hold, busy, done, error;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_count;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] words [256];
    logic [7:0]  tx_q [$];
    logic [7:0]  obs_a [$];
    logic [31:0] obs_d [$];
    imem_loader #(.ADDR_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );
    always #5 CLK = ~CLK;
    always @(negedge CLK)
        if (mem_we) begin
            obs_a.push_back(mem_addr);
            obs_d.push_back(mem_wdata);
        end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask
    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask
    // mode 0: always valid, 1: valid toggles every cycle, 2: random stalls
    task automatic send(input int mode, output int sent);
        int  idle = 0;
        bit  tog = 1'b1, v;
        sent = 0;
        while (sent < tx_q.size() && idle < 50) begin
            @(negedge CLK);
            v = mode == 0 ? 1'b1 : mode == 1 ? tog : ($urandom_range(0, 2) != 0);
            tog = ~tog;
            byte_valid = v;
            byte_data = tx_q[sent];
            if (v && byte_ready) begin
                sent++;
                idle = 0;
            end else idle++;
        end
        @(negedge CLK);
        byte_valid = 1'b0;
    endtask
    task automatic run_load(input int n, input bit bad_cs, input int mode);
        logic [7:0] cs = '0, bt;
        bit legal = n >= 1 && n <= 256;
        bit ok = legal;
        int sent, exp_nw;
        obs_a = {};
        obs_d = {};
        pulse_start();
        check("start_busy", busy, 1);
        check("start_hold", cpu_hold, 1);
        check("start_done", done, 0);
        tx_q = {};
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        if (legal)
            for (int i = 0; i < n; i++)
                for (int b = 0; b < 4; b++) begin
                    bt = words[i][8*b +: 8];
                    tx_q.push_back(bt);
                    cs ^= bt;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (legal) tx_q.push_back(cs ^ {7'd0, bad_cs});
        ok = legal && !bad_cs;
`endif
        send(mode, sent);
        check("sent", sent, tx_q.size());
        repeat (4) @(negedge CLK);
        exp_nw = legal ? n : 0;
        check("nwrites", obs_a.size(), exp_nw);
        for (int i = 0; i < exp_nw && i < obs_a.size(); i++) begin
            check("addr", obs_a[i], i);
            check("data", obs_d[i], words[i]);
        end
        check("done", done, ok);
        check("error", error, !ok);
        check("cpu_hold", cpu_hold, !ok);
        check("busy", busy, 0);
        check("word_count", word_count, exp_nw);
        check("ready_idle", byte_ready, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int sent;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        check("rst_ready", byte_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_wc", word_count, 0);
        words[0] = 32'h00500093;
        words[1] = 32'h00A00113;
        run_load(2, 0, 0);
        run_load(2, 1, 0);
        run_load(257, 0, 0);
        run_load(0, 0, 0);
        run_load(2, 0, 1);
        run_load(2, 0, 2);
        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            run_load(n, $urandom_range(0, 3) == 0, $urandom_range(0, 2));
        end
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        run_load(256, 0, 0);
        words[0] = 32'h00500093;
        words[1] = 32'h00A00113;
        obs_a = {};
        obs_d = {};
        pulse_start();
        tx_q = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
        send(0, sent);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check("mid_writes", obs_a.size(), 1);
        check("mid_ready", byte_ready, 0);
        check("mid_hold", cpu_hold, 1);
        check("mid_busy", busy, 0);
        check("mid_wc", word_count, 0);
        check("mid_we", mem_we, 0);
        obs_a = {};
        repeat (10) @(negedge CLK);
        check("mid_nowrite", obs_a.size(), 0);
        run_load(2, 0, 0);
        check("pre_reload_hold", cpu_hold, 0);
        words[0] = 32'hDEADBEEF;
        run_load(1, 0, 0);
        do_reset();
        check("final_rst_done", done, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
